// File: rtl/bus_init_serializer.sv
// Serialises a write request onto a one-bit initiator bus. The address goes out
// first (16 bits, LSB first), then the write data is sent once a target selects.
module bus_init_serializer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SEL_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    input  logic              tgt_selected,
    input  logic              tgt_ready,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned WAIT_W = $clog2(SEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        WAIT_SEL = 3'd2,
        DATA     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_sr;
    logic [DATA_W-1:0]   data_sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_inc;
    logic                done_d;
    logic                err_d;
    logic                bit_c;
    logic                addr_last;
    logic                data_last;

    assign wait_inc  = wait_cnt + WAIT_W'(1);
    assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));

    // State register and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = ADDR;
            end
            ADDR: begin
                if (addr_last) state_d = WAIT_SEL;
            end
            WAIT_SEL: begin
                if (tgt_selected) begin
                    state_d = DATA;
                end else if (wait_inc == WAIT_W'(SEL_TIMEOUT)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DATA: begin
                // Losing the target mid-transfer aborts the whole transaction
                if (!tgt_selected) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (tgt_ready && data_last) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!tgt_selected) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready          = 1'b0;
        bus_data_out_valid = 1'b0;
        bus_mode           = 1'b0;
        busy               = 1'b1;
        bit_c              = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ADDR: begin
                bus_data_out_valid = 1'b1;
                bit_c              = addr_sr[0];
            end
            DATA: begin
                bus_mode           = 1'b1;
                bus_data_out_valid = tgt_ready;
                bit_c              = data_sr[0];
            end
            default: ;
        endcase
    end

    assign bus_data_out = bus_data_out_valid & bit_c;

    // Shift registers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_sr  <= '0;
            data_sr  <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_sr  <= req_addr;
                        data_sr  <= req_wdata;
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                    end
                end
                ADDR: begin
                    addr_sr  <= addr_sr >> 1;
                    bit_cnt  <= addr_last ? '0 : bit_cnt + CNT_W'(1);
                    wait_cnt <= '0;
                end
                WAIT_SEL: begin
                    if (!tgt_selected) wait_cnt <= wait_inc;
                end
                DATA: begin
                    if (tgt_selected && tgt_ready) begin
                        data_sr <= data_sr >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_init_serializer.md
BUS_INIT_SERIALIZER -- requirements
Module: bus_init_serializer

Interface
REQ-001 Parameter DATA_W, 8, write-data width in bits (1..16).
REQ-002 Parameter SEL_TIMEOUT, 8, maximum cycles to wait for target selection after the last address bit (1..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a write request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_addr  input  16  target address of the request.
REQ-008 req_wdata  input  DATA_W  write data of the request.
REQ-009 bus_data_out  output  1  serial bit to the bus, LSB first.
REQ-010 bus_data_out_valid  output  1  bus_data_out carries a valid bit this cycle.
REQ-011 bus_mode  output  1  1 = data phase, 0 = address phase or idle.
REQ-012 tgt_selected  input  1  OR of the address-decoder target valids.
REQ-013 tgt_ready  input  1  selected target accepts a data bit this cycle.
REQ-014 done  output  1  one-cycle pulse on transaction completion.
REQ-015 err  output  1  one-cycle pulse on selection timeout.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL use states IDLE, ADDR, WAIT_SEL, DATA, WAIT_REL.
REQ-018 IDLE: req_ready=1, bus_data_out_valid=0, bus_mode=0; req_valid=1 latches req_addr and req_wdata into shift registers and moves to ADDR next cycle.
REQ-019 req_ready SHALL be high only in IDLE; req_addr and req_wdata are sampled only on the accepting edge (req_valid & req_ready).
REQ-020 ADDR: bus_mode=0, bus_data_out_valid=1 for exactly 16 consecutive cycles, bit k of the address driven in the k-th cycle (k=0..15), no gaps.
REQ-021 After the 16th address bit the FSM SHALL enter WAIT_SEL with bus_data_out_valid=0, bus_mode=0, and a wait counter cleared to 0.
REQ-022 WAIT_SEL: tgt_selected=1 moves to DATA next cycle; otherwise the counter increments, and when it reaches SEL_TIMEOUT the FSM pulses err for one cycle and returns to IDLE.
REQ-023 The timeout counter SHALL be wide enough for SEL_TIMEOUT without wrap-around; err and done SHALL never assert in the same cycle.
REQ-024 DATA: bus_mode=1; bus_data_out_valid=tgt_ready; the data shift register advances one bit (LSB first) only in cycles where tgt_ready=1.
REQ-025 When the DATA_W-th data bit is transferred (tgt_ready=1), the FSM SHALL enter WAIT_REL with bus_mode=0, bus_data_out_valid=0.
REQ-026 DATA: tgt_selected falling to 0 before all bits are sent SHALL abort the transaction: err pulse, return to IDLE.
REQ-027 WAIT_REL: when tgt_selected=0 the FSM SHALL pulse done for one cycle and return to IDLE; no timeout applies.
REQ-028 bus_data_out SHALL be 0 whenever bus_data_out_valid=0.
REQ-029 A request arriving while busy=1 is held off by req_ready=0 and SHALL NOT be lost or corrupted.
REQ-030 Back-to-back requests SHALL produce at least one IDLE cycle with bus_data_out_valid=0 and bus_mode=0 between transactions (resynchronises the decoder's bit counter).

Reset
REQ-031 rst_n low SHALL force state IDLE immediately: req_ready=1, bus_data_out=0, bus_data_out_valid=0, bus_mode=0, done=0, err=0, busy=0, and all shift registers and counters cleared.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no done or err pulse; the first cycle after release is IDLE.

Verification
REQ-033 Addr 0x0123, wdata 0xA5, tgt_selected rises 2 cycles after the last address bit, tgt_ready=1 -> address bits 1,1,0,0,0,1,0,0,1,0,0,0,0,0,0,0 with mode 0, then data bits 1,0,1,0,0,1,0,1 with mode 1, done once tgt_selected drops.
REQ-034 Addr 0xC000, tgt_selected stays 0 -> err pulses exactly SEL_TIMEOUT (8) cycles after WAIT_SEL entry; no bus_mode=1 cycle.
REQ-035 DATA phase with tgt_ready toggling 1,0,1,0... -> exactly 8 valid data bits, stream identical to REQ-033, no bit repeated or skipped.
REQ-036 req_valid held high across two requests -> second accepted only after done, with at least one idle bus cycle between.
REQ-037 rst_n pulsed low at the 5th data bit -> all outputs at reset values within the cycle; no done or err; next request completes normally.
REQ-038 tgt_selected drops after 3 data bits -> err pulse, IDLE, bus_mode=0.
